byang_host_link: RTL and testbench

Host-side master for the byte-serial modular-inverse port of the Bernstein-Yang secp256k1 inverter die. It accepts a 256-bit operand on a valid/ready request channel. It drives the chip pins: 32 write strobes, MSB byte first, then a poll of the device valid pin, then 31 read strobes. The 256-bit result, or a timeout error, is returned on a valid/ready response channel. It lives in the FPGA/controller side of the test and characterisation harness and is the exact counterpart of the chip's load/busy/read pin protocol.

---
 rtl/byang_host_link_pkg.sv | 29 ++
 rtl/byang_sync2.sv | 23 ++
 rtl/byang_host_link.sv | 204 ++++++++++++++++++++
 tb/tb_byang_host_link.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byang_host_link_pkg.sv
// Shared definitions for the Bernstein-Yang host link: FSM encoding,
// transfer geometry and the secp256k1 field prime.
package byang_host_link_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_WR_SETUP,
        ST_WR_HI,
        ST_WR_LO,
        ST_WAIT,
        ST_RD_SETTLE,
        ST_RD_HI,
        ST_RD_LO,
        ST_RESP
    } state_t;

    // Bytes per operand/result on the 8-bit chip port.
    localparam int BYANG_NBYTES = 32;

    // secp256k1 field prime; the chip returns inverses modulo this value.
    localparam logic [255:0] BYANG_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    function automatic int byang_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/byang_sync2.sv
// Two-flop synchronizer for single-bit status pins coming off the chip.
module byang_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops; both clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking keeps meta and q as two distinct stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/byang_host_link.sv
// Host-side master for the byte-serial modular-inverse chip port: writes a
// 256-bit operand MSB byte first, waits for the result, reads it back.
import byang_host_link_pkg::*;

module byang_host_link #(
    parameter int PULSE_HI = 2,
    parameter int PULSE_LO = 2,
    parameter int SETTLE   = 3,
    parameter int TIMEOUT  = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [255:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_data,
    output logic         rsp_err,
    output logic [7:0]   dev_din,
    input  logic [7:0]   dev_dout,
    output logic         dev_wr,
    output logic         dev_rd,
    input  logic         dev_ready,
    input  logic         dev_valid
);

    // One phase counter serves every timed state, so it is sized for the longest.
    localparam int CNT_MAX = byang_max(byang_max(PULSE_HI, PULSE_LO),
                                       byang_max(SETTLE, TIMEOUT));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(PULSE_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(PULSE_LO - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]       LAST_BYTE = 5'(BYANG_NBYTES - 1);

    state_t           state;
    logic [255:0]     shift;
    logic [4:0]       byte_cnt;
    logic [CNT_W-1:0] cnt;
    logic             ready_s;
    logic             valid_s;

    byang_sync2 u_sync_ready (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dev_ready),
        .q     (ready_s)
    );

    byang_sync2 u_sync_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dev_valid),
        .q     (valid_s)
    );

    // Transfer FSM; every output is a register so the chip pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: async reset drops the strobes immediately, even mid-pulse.
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift     <= '0;
            byte_cnt  <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            dev_din   <= 8'h00;
            dev_wr    <= 1'b0;
            dev_rd    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        shift     <= req_data;
                        byte_cnt  <= '0;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_START;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                // The chip takes a fresh load from LOAD (ready) or READ (valid).
                ST_START: begin
                    if (ready_s || valid_s) begin
                        dev_din <= shift[255:248];
                        state   <= ST_WR_SETUP;
                    end else if (cnt == TO_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WR_SETUP: begin
                    dev_wr <= 1'b1;
                    cnt    <= '0;
                    state  <= ST_WR_HI;
                end

                ST_WR_HI: begin
                    if (cnt == HI_LAST) begin
                        dev_wr <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_WR_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Next byte is presented on entry to WR_SETUP so it is stable before dev_wr rises.
                ST_WR_LO: begin
                    if (cnt == LO_LAST) begin
                        cnt   <= '0;
                        shift <= {shift[247:0], 8'h00};
                        if (byte_cnt == LAST_BYTE) begin
                            state <= ST_WAIT;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                            dev_din  <= shift[247:240];
                            state    <= ST_WR_SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (valid_s) begin
                        byte_cnt <= '0;
                        cnt      <= '0;
                        state    <= ST_RD_SETTLE;
                    end else if (cnt == TO_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // dev_dout is quasi-static; sample it only after it has had SETTLE cycles.
                ST_RD_SETTLE: begin
                    if (cnt == SET_LAST) begin
                        cnt   <= '0;
                        shift <= {shift[247:0], dev_dout};
                        if (byte_cnt == LAST_BYTE) begin
                            rsp_data  <= {shift[247:0], dev_dout};
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                            dev_rd   <= 1'b1;
                            state    <= ST_RD_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RD_HI: begin
                    if (cnt == HI_LAST) begin
                        dev_rd <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_RD_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RD_LO: begin
                    if (cnt == LO_LAST) begin
                        cnt   <= '0;
                        state <= ST_RD_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byang_host_link.sv
// Directed bench for byang_host_link with a behavioural model of the
// inverter chip's load/busy/read pin protocol.
module tb_byang_host_link;
    import byang_host_link_pkg::*;

    localparam int PH   = 2;
    localparam int PL   = 2;
    localparam int SE   = 3;
    localparam int TO   = 4096;
    localparam int CDLY = 742;

    localparam logic [255:0] INV2 =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;
    // First dev_wr rise to last dev_wr fall: 31 full byte slots plus one high pulse.
    localparam int WR_SPAN = (BYANG_NBYTES - 1) * (1 + PH + PL) + PH;
    // Chip valid rise to rsp_valid: 2 sync stages, 1 cycle for WAIT to react, then the read phase.
    localparam int RD_LAT  = 2 + 1 + BYANG_NBYTES * SE + (BYANG_NBYTES - 1) * (PH + PL);

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [255:0] req_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_data;
    logic         rsp_err;
    logic [7:0]   dev_din;
    logic [7:0]   dev_dout;
    logic         dev_wr;
    logic         dev_rd;
    logic         dev_ready;
    logic         dev_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    byang_host_link #(
        .PULSE_HI (PH),
        .PULSE_LO (PL),
        .SETTLE   (SE),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dev_din   (dev_din),
        .dev_dout  (dev_dout),
        .dev_wr    (dev_wr),
        .dev_rd    (dev_rd),
        .dev_ready (dev_ready),
        .dev_valid (dev_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Modular inverse by Fermat: a^(p-2) mod p.
    function automatic logic [255:0] mod_inv(input logic [255:0] a);
        logic [511:0] r;
        logic [511:0] b;
        logic [511:0] m;
        logic [255:0] e;
        r = 512'd1;
        b = {256'd0, a};
        m = {256'd0, BYANG_P};
        e = BYANG_P - 256'd2;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r[255:0];
    endfunction

    // ---------------- chip model + pin monitor ----------------
    int           m_mode;   // 0 LOAD, 1 BUSY, 2 READ
    int           m_cnt;
    int           m_busy;
    int           m_idx;
    logic [255:0] m_op;
    logic [255:0] m_res;
    logic         m_hang;
    logic         chip_rst_n;
    logic         prev_wr = 1'b0;
    logic         prev_rd = 1'b0;
    int           wr_edges = 0;
    int           rd_edges = 0;
    int           gap_bad = 0;
    int           overlap_bad = 0;
    int           wr_low = 1000;
    int           rd_low = 1000;
    int           first_wr_cyc = 0;
    int           last_wr_fall_cyc = 0;
    int           valid_cyc = 0;

    always @(negedge clk) begin
        logic wr_rise;
        logic rd_rise;
        wr_rise = dev_wr && !prev_wr;
        rd_rise = dev_rd && !prev_rd;
        if (!chip_rst_n) begin
            m_mode = 0; m_cnt = 0; m_busy = 0; m_idx = 0;
            m_op = '0; m_res = '0; dev_dout = 8'h00;
        end else begin
            case (m_mode)
                0: if (wr_rise) begin
                    if (m_cnt == 0) first_wr_cyc = cyc;
                    m_op  = {m_op[247:0], dev_din};
                    m_cnt = m_cnt + 1;
                    if (m_cnt == BYANG_NBYTES) begin
                        m_mode = 1;
                        m_busy = 0;
                    end
                end
                1: begin
                    m_busy = m_busy + 1;
                    if (!m_hang && m_busy >= CDLY) begin
                        m_res     = mod_inv(m_op);
                        m_idx     = 0;
                        dev_dout  = m_res[255:248];
                        valid_cyc = cyc;
                        m_mode    = 2;
                    end
                end
                default: if (wr_rise) begin
                    first_wr_cyc = cyc;
                    m_op     = {m_op[247:0], dev_din};
                    m_cnt    = 1;
                    dev_dout = 8'h00;
                    m_mode   = 0;
                end else if (rd_rise) begin
                    logic [255:0] sh;
                    m_idx    = m_idx + 1;
                    sh       = m_res >> (8 * (BYANG_NBYTES - 1 - m_idx));
                    dev_dout = sh[7:0];
                end
            endcase
        end
        dev_ready = chip_rst_n && (m_mode == 0);
        dev_valid = chip_rst_n && (m_mode == 2);

        if (wr_rise) begin
            wr_edges = wr_edges + 1;
            if (wr_low < PL) gap_bad = gap_bad + 1;
        end
        if (rd_rise) begin
            rd_edges = rd_edges + 1;
            if (rd_low < PL) gap_bad = gap_bad + 1;
        end
        if (!dev_wr && prev_wr) last_wr_fall_cyc = cyc;
        if (dev_wr && dev_rd) overlap_bad = overlap_bad + 1;
        wr_low  = dev_wr ? 0 : wr_low + 1;
        rd_low  = dev_rd ? 0 : rd_low + 1;
        prev_wr = dev_wr;
        prev_rd = dev_rd;
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic send_req(input logic [255:0] op);
        int n;
        n = 0;
        req_data  = op;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_handshake: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int at_cyc);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        at_cyc = cyc;
        if (rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic chip_reset();
        chip_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chip_rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; chip_rst_n = 1'b0; m_hang = 1'b0;
        req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dev_wr, dev_rd, rsp_valid, rsp_err, req_ready} !== 5'b0 ||
            rsp_data !== 256'd0 || dev_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: wr=%b rd=%b rsp_valid=%b rsp_err=%b req_ready=%b din=%h, required all 0",
                     dev_wr, dev_rd, rsp_valid, rsp_err, req_ready, dev_din);
        end
        rst_n = 1'b1; chip_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: req_ready=%b, required 1", req_ready);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_inv_one();
        int wr0, rd0, at;
        wr0 = wr_edges; rd0 = rd_edges;
        send_req(256'd1);
        wait_rsp(3000, at);
        checks++;
        if (rsp_data !== 256'd1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL inv_one_data: data=%h err=%b, required 1 err=0", rsp_data, rsp_err);
        end
        checks++;
        if (wr_edges - wr0 !== 32 || rd_edges - rd0 !== 31) begin
            errors++;
            $display("FAIL inv_one_edges: wr=%0d rd=%0d, required 32 and 31", wr_edges - wr0, rd_edges - rd0);
        end
        checks++;
        if (last_wr_fall_cyc - first_wr_cyc !== WR_SPAN) begin
            errors++;
            $display("FAIL write_timing: span=%0d, required %0d", last_wr_fall_cyc - first_wr_cyc, WR_SPAN);
        end
        checks++;
        if (at - valid_cyc !== RD_LAT) begin
            errors++;
            $display("FAIL read_timing: latency=%0d, required %0d", at - valid_cyc, RD_LAT);
        end
        accept_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_accept: rsp_valid=%b req_ready=%b, required 0 and 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_inv_two();
        int at;
        send_req(256'd2);
        wait_rsp(3000, at);
        checks++;
        if (rsp_data !== INV2 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL inv_two_data: data=%h err=%b, required %h err=0", rsp_data, rsp_err, INV2);
        end
        accept_rsp();
    endtask

    task automatic test_hold();
        int at, stable_bad, rdy_bad, strobe_bad, wr0;
        logic [255:0] snap;
        stable_bad = 0; rdy_bad = 0; strobe_bad = 0;
        send_req(256'd1);
        wait_rsp(3000, at);
        snap = rsp_data;
        wr0  = wr_edges;
        req_valid = 1'b1;
        req_data  = {256{1'b1}};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_data !== snap || rsp_valid !== 1'b1 || rsp_err !== 1'b0) stable_bad++;
            if (req_ready !== 1'b0) rdy_bad++;
            if (dev_wr !== 1'b0 || dev_rd !== 1'b0) strobe_bad++;
        end
        req_valid = 1'b0;
        checks++;
        if (stable_bad != 0 || snap !== 256'd1) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, data=%h, required 0 and 1", stable_bad, snap);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL hold_req_ready: high in %0d cycles, required 0", rdy_bad);
        end
        checks++;
        if (strobe_bad != 0 || wr_edges != wr0) begin
            errors++;
            $display("FAIL hold_strobes: %0d strobe cycles, required 0", strobe_bad);
        end
        accept_rsp();
    endtask

    task automatic test_back_to_back();
        int at;
        send_req(256'd1);
        wait_rsp(3000, at);
        checks++;
        if (rsp_data !== 256'd1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: data=%h err=%b, required 1 err=0", rsp_data, rsp_err);
        end
        accept_rsp();
        send_req(256'd2);
        wait_rsp(3000, at);
        checks++;
        if (rsp_data !== INV2 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: data=%h err=%b, required %h err=0", rsp_data, rsp_err, INV2);
        end
        accept_rsp();
    endtask

    task automatic test_timeout();
        int wr0, rd0, at;
        m_hang = 1'b1;
        wr0 = wr_edges; rd0 = rd_edges;
        send_req(256'd3);
        wait_rsp(6000, at);
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 256'd0) begin
            errors++;
            $display("FAIL timeout_err: err=%b data=%h, required err=1 data=0", rsp_err, rsp_data);
        end
        checks++;
        if (at - last_wr_fall_cyc !== PL + TO) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles after last wr fall, required %0d", at - last_wr_fall_cyc, PL + TO);
        end
        checks++;
        if (wr_edges - wr0 !== 32 || rd_edges - rd0 !== 0) begin
            errors++;
            $display("FAIL timeout_edges: wr=%0d rd=%0d, required 32 and 0", wr_edges - wr0, rd_edges - rd0);
        end
        accept_rsp();
        m_hang = 1'b0;
        chip_reset();
    endtask

    task automatic test_reset_mid();
        int wr0, n, at;
        wr0 = wr_edges;
        n   = 0;
        send_req(BYANG_P - 256'd1);
        while (!((wr_edges - wr0) == 11 && dev_wr === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dev_wr !== 1'b1 || dev_din !== 8'hFF) begin
            errors++;
            $display("FAIL midrst_pre: wr=%b din=%h, required 1 and ff", dev_wr, dev_din);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dev_wr !== 1'b0 || dev_rd !== 1'b0 || rsp_valid !== 1'b0 || dev_din !== 8'h00) begin
            errors++;
            $display("FAIL midrst_zero: wr=%b rd=%b rsp_valid=%b din=%h, required all 0",
                     dev_wr, dev_rd, rsp_valid, dev_din);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: req_ready=%b rsp_valid=%b, required 1 and 0", req_ready, rsp_valid);
        end
        chip_reset();
        send_req(256'd2);
        wait_rsp(3000, at);
        checks++;
        if (rsp_data !== INV2 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_recover: data=%h err=%b, required %h err=0", rsp_data, rsp_err, INV2);
        end
        accept_rsp();
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (gap_bad != 0 || overlap_bad != 0) begin
            errors++;
            $display("FAIL strobe_rules: gap violations=%0d overlaps=%0d, required 0 and 0", gap_bad, overlap_bad);
        end
    endtask

    initial begin
        test_reset();
        test_inv_one();
        test_inv_two();
        test_hold();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
